tdp_ram_sclk_gen2: RTL and testbench

Parametrised single-clock true dual-port RAM. It succeeds the fixed 8-bit × 64-word dual-port RAM. It adds per-port enables, byte-write enables, a selectable read-during-write mode, an optional output register, deterministic same-address write arbitration with a collision flag, and a post-reset zero-fill sequencer. It is the shared on-chip buffer for packet and coefficient storage; both ports belong to the same clock domain.

---
 rtl/tdp_ram_sclk_gen2_pkg.sv | 23 ++
 rtl/tdp_ram_sclk_gen2_if.sv | 17 +
 rtl/tdp_ram_sclk_gen2_out_stage.sv | 36 +++
 rtl/tdp_ram_sclk_gen2.sv | 142 ++++++++++++++
 tb/tb_tdp_ram_sclk_gen2.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdp_ram_sclk_gen2_pkg.sv
// Shared types for the single-clock true dual-port RAM.
package tdp_ram_pkg;

    typedef enum logic {
        RDW_WRITE_FIRST = 1'b0,
        RDW_READ_FIRST  = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } fill_state_e;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } wr_pri_e;

    localparam int NUM_PORTS = 2;
    localparam int PORT_A    = 0;
    localparam int PORT_B    = 1;

endpackage

// File: rtl/tdp_ram_sclk_gen2_if.sv
// One RAM access port: request fields in, read data and valid out.
interface tdp_ram_port_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int BE_W   = DATA_W / 8
);
    logic              en;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] q;
    logic              qv;

    modport master (output en, we, be, addr, data, input  q, qv);
    modport slave  (input  en, we, be, addr, data, output q, qv);
endinterface

// File: rtl/tdp_ram_sclk_gen2_out_stage.sv
// Per-port read-data pipeline: one mandatory register plus OUT_REG extra
// stages. Data registers only load on a valid beat so q holds between accesses.
module tdp_ram_out_stage #(
    parameter int DATA_W  = 8,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] q,
    output logic              qv
);
    localparam int STAGES = OUT_REG;

    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0][DATA_W-1:0] dat_pipe;

    // Shift valid every cycle; advance data only behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= vld_in;
            if (vld_in) dat_pipe[0] <= d_in;
            for (int s = 1; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign q  = dat_pipe[STAGES];
    assign qv = vld_pipe[STAGES];
endmodule

// File: rtl/tdp_ram_sclk_gen2.sv
// Single-clock true dual-port RAM with byte enables, read-during-write mode,
// same-address write arbitration, collision flag and post-reset zero fill.
module tdp_ram_sclk_gen2
    import tdp_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int BE_W     = DATA_W / 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0,
    parameter int WR_PRI   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            init_done,
    output logic            collision,
    tdp_ram_port_if.slave   port_a,
    tdp_ram_port_if.slave   port_b
);
    localparam int        D   = 2 ** ADDR_W;
    localparam rdw_mode_e RDW = (RDW_MODE != 0) ? RDW_READ_FIRST : RDW_WRITE_FIRST;
    localparam wr_pri_e   PRI = (WR_PRI != 0) ? PRI_B : PRI_A;
    localparam int        WIN = (PRI == PRI_B) ? PORT_B : PORT_A;

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              fill_we;
    logic              ready;

    logic [DATA_W-1:0] mem [D];

    logic [NUM_PORTS-1:0]             en, we, acc, wr;
    logic [NUM_PORTS-1:0][BE_W-1:0]   be;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata, old_w, new_w, rd_word, q_v;
    logic [NUM_PORTS-1:0]             qv_v;
    logic                             same_addr;
    logic                             col_hit;

    // Flatten the two interfaces into port-indexed vectors.
    assign en[PORT_A]    = port_a.en;
    assign we[PORT_A]    = port_a.we;
    assign be[PORT_A]    = port_a.be;
    assign addr[PORT_A]  = port_a.addr;
    assign wdata[PORT_A] = port_a.data;
    assign en[PORT_B]    = port_b.en;
    assign we[PORT_B]    = port_b.we;
    assign be[PORT_B]    = port_b.be;
    assign addr[PORT_B]  = port_b.addr;
    assign wdata[PORT_B] = port_b.data;

    // Fill FSM state and address counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Walk every address once writing zero, then hand the array to the ports.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_we = 1'b0;
        case (state_q)
            FILL: begin
                fill_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(D - 1)) state_d = READY;
            end
            READY: ;
            default: state_d = FILL;
        endcase
    end

    assign ready     = (state_q == READY);
    assign init_done = ready;
    assign acc       = en & {NUM_PORTS{ready}};
    assign wr        = acc & we;
    assign same_addr = (addr[PORT_A] == addr[PORT_B]);

    // Byte merge: each port's target word as it will look after this edge,
    // folding in the other port's bytes when both hit the same address.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            old_w[p] = mem[addr[p]];
            new_w[p] = old_w[p];
            for (int b = 0; b < BE_W; b++) begin
                if (wr[p] && be[p][b] && same_addr && wr[1-p] && be[1-p][b])
                    new_w[p][8*b +: 8] = wdata[WIN][8*b +: 8];
                else if (wr[p] && be[p][b])
                    new_w[p][8*b +: 8] = wdata[p][8*b +: 8];
                else if (same_addr && wr[1-p] && be[1-p][b])
                    new_w[p][8*b +: 8] = wdata[1-p][8*b +: 8];
            end
            // Reads always see the pre-edge word; writes follow RDW.
            rd_word[p] = (we[p] && RDW == RDW_WRITE_FIRST) ? new_w[p] : old_w[p];
        end
    end

    assign col_hit = wr[PORT_A] & wr[PORT_B] & same_addr & (|(be[PORT_A] & be[PORT_B]));

    // Array write: fill zeros, otherwise merged port words (identical on a shared address).
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (fill_we) begin
                mem[cnt_q] <= '0;
            end else begin
                for (int p = 0; p < NUM_PORTS; p++)
                    if (wr[p]) mem[addr[p]] <= new_w[p];
            end
        end
    end

    // Collision flag, registered once and never delayed by the output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) collision <= 1'b0;
        else        collision <= col_hit;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        tdp_ram_out_stage #(
            .DATA_W  (DATA_W),
            .OUT_REG (OUT_REG)
        ) u_out (
            .clk    (clk),
            .rst_n  (rst_n),
            .vld_in (acc[p]),
            .d_in   (rd_word[p]),
            .q      (q_v[p]),
            .qv     (qv_v[p])
        );
    end

    assign port_a.q  = q_v[PORT_A];
    assign port_a.qv = qv_v[PORT_A];
    assign port_b.q  = q_v[PORT_B];
    assign port_b.qv = qv_v[PORT_B];
endmodule

// File: tb/tb_tdp_ram_sclk_gen2.sv
// Bench: two RAM instances share one stimulus stream.
//   dut0: write-first, no output reg, A wins.  dut1: read-first, output reg, B wins.
module tb_tdp_ram_sclk_gen2;
    logic clk;
    logic rst_n;

    logic        en   [2];
    logic        we   [2];
    logic [1:0]  be   [2];
    logic [3:0]  addr [2];
    logic [15:0] dat  [2];

    logic [15:0] q_o   [2][2];
    logic        qv_o  [2][2];
    logic        col_o [2];
    logic        init_o[2];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [15:0] mm     [2][16];
    logic [15:0] exp_q  [2][2];
    logic        exp_qv [2][2];
    logic [15:0] st_q   [2][2];
    logic        st_qv  [2][2];
    logic        exp_col[2];
    logic        mready;
    int          fcnt;

    tdp_ram_port_if #(.DATA_W(16), .ADDR_W(4)) ia0 ();
    tdp_ram_port_if #(.DATA_W(16), .ADDR_W(4)) ib0 ();
    tdp_ram_port_if #(.DATA_W(16), .ADDR_W(4)) ia1 ();
    tdp_ram_port_if #(.DATA_W(16), .ADDR_W(4)) ib1 ();

    assign ia0.en = en[0]; assign ia0.we = we[0]; assign ia0.be = be[0]; assign ia0.addr = addr[0]; assign ia0.data = dat[0];
    assign ib0.en = en[1]; assign ib0.we = we[1]; assign ib0.be = be[1]; assign ib0.addr = addr[1]; assign ib0.data = dat[1];
    assign ia1.en = en[0]; assign ia1.we = we[0]; assign ia1.be = be[0]; assign ia1.addr = addr[0]; assign ia1.data = dat[0];
    assign ib1.en = en[1]; assign ib1.we = we[1]; assign ib1.be = be[1]; assign ib1.addr = addr[1]; assign ib1.data = dat[1];

    assign q_o[0][0] = ia0.q;  assign qv_o[0][0] = ia0.qv;
    assign q_o[0][1] = ib0.q;  assign qv_o[0][1] = ib0.qv;
    assign q_o[1][0] = ia1.q;  assign qv_o[1][0] = ia1.qv;
    assign q_o[1][1] = ib1.q;  assign qv_o[1][1] = ib1.qv;

    tdp_ram_sclk_gen2 #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .WR_PRI(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .init_done(init_o[0]), .collision(col_o[0]),
        .port_a(ia0.slave), .port_b(ib0.slave));

    tdp_ram_sclk_gen2 #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1), .WR_PRI(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .init_done(init_o[1]), .collision(col_o[1]),
        .port_a(ia1.slave), .port_b(ib1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "timeout");
    end

    // Word stored at address a after this cycle's writes in instance d.
    function automatic logic [15:0] final_word(int d, logic [3:0] a, logic [15:0] old);
        logic [15:0] w;
        bit wa, wb;
        w = old;
        for (int k = 0; k < 2; k++) begin
            wa = en[0] && we[0] && addr[0] == a && be[0][k];
            wb = en[1] && we[1] && addr[1] == a && be[1][k];
            if (wa && wb)  w[8*k +: 8] = (d == 1) ? dat[1][8*k +: 8] : dat[0][8*k +: 8];
            else if (wa)   w[8*k +: 8] = dat[0][8*k +: 8];
            else if (wb)   w[8*k +: 8] = dat[1][8*k +: 8];
        end
        return w;
    endfunction

    // Advance the reference model by one rising edge using current inputs.
    task automatic model_edge();
        bit          was_ready;
        logic [15:0] old  [2];
        logic [15:0] fin  [2];
        logic [15:0] rq;
        bit          rv;
        was_ready = mready;
        if (!rst_n) begin
            fcnt = 0;
            mready = 1'b0;
            for (int d = 0; d < 2; d++) begin
                exp_col[d] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    exp_q[d][p] = '0; exp_qv[d][p] = 1'b0;
                    st_q[d][p]  = '0; st_qv[d][p]  = 1'b0;
                end
            end
            return;
        end
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                old[p] = mm[d][addr[p]];
                fin[p] = final_word(d, addr[p], old[p]);
            end
            for (int p = 0; p < 2; p++) begin
                rv = was_ready && en[p];
                rq = (we[p] && d == 0) ? fin[p] : old[p];
                if (d == 1) begin
                    exp_qv[d][p] = st_qv[d][p];
                    if (st_qv[d][p]) exp_q[d][p] = st_q[d][p];
                    st_qv[d][p] = rv;
                    if (rv) st_q[d][p] = rq;
                end else begin
                    exp_qv[d][p] = rv;
                    if (rv) exp_q[d][p] = rq;
                end
            end
            exp_col[d] = was_ready && en[0] && we[0] && en[1] && we[1] &&
                         addr[0] == addr[1] && ((be[0] & be[1]) != 2'b00);
            if (was_ready) begin
                for (int p = 0; p < 2; p++)
                    if (en[p] && we[p]) mm[d][addr[p]] = fin[p];
            end
        end
        if (!was_ready) begin
            fcnt++;
            if (fcnt == 16) begin
                mready = 1'b1;
                for (int d = 0; d < 2; d++)
                    for (int i = 0; i < 16; i++) mm[d][i] = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            en[p] = 1'b0; we[p] = 1'b0; be[p] = 2'b00; addr[p] = '0; dat[p] = '0;
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (init_o[d] !== 1'b0 || col_o[d] !== 1'b0 || q_o[d][0] !== 16'h0 || q_o[d][1] !== 16'h0 ||
                qv_o[d][0] !== 1'b0 || qv_o[d][1] !== 1'b0) begin
                n_err++;
                $display("FAIL reset dut%0d: init=%b col=%b qa=%h qb=%h qva=%b qvb=%b, required all 0",
                         d, init_o[d], col_o[d], q_o[d][0], q_o[d][1], qv_o[d][0], qv_o[d][1]);
            end
        end
    endtask

    // Release reset with reads pending; they must be ignored until init_done.
    task automatic test_fill();
        en[0] = 1'b1; addr[0] = 4'd0;
        en[1] = 1'b1; addr[1] = 4'd1;
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (init_o[d] !== (i == 16) || qv_o[d][0] !== 1'b0 || qv_o[d][1] !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill dut%0d edge %0d: init=%b qva=%b qvb=%b, required init=%b qv=0",
                             d, i, init_o[d], qv_o[d][0], qv_o[d][1], i == 16);
                end
            end
        end
        idle();
    endtask

    task automatic test_zero_reads();
        for (int i = 0; i < 16; i++) begin
            en[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'(i);
            en[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'(15 - i);
            step();
            n_vec++;
            if (q_o[0][0] !== 16'h0 || q_o[0][1] !== 16'h0 || qv_o[0][0] !== 1'b1 || qv_o[0][1] !== 1'b1) begin
                n_err++;
                $display("FAIL zero_read addr %0d: qa=%h qb=%h qva=%b qvb=%b, required 0000/0000 qv=1",
                         i, q_o[0][0], q_o[0][1], qv_o[0][0], qv_o[0][1]);
            end
        end
        idle();
        step();
        n_vec++;
        if (q_o[1][0] !== 16'h0 || qv_o[1][0] !== 1'b1) begin
            n_err++;
            $display("FAIL zero_read L2 tail: qa=%h qva=%b, required 0000 qv=1", q_o[1][0], qv_o[1][0]);
        end
    endtask

    task automatic test_byte_write();
        idle();
        en[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd3; dat[0] = 16'hBEEF; be[0] = 2'b11; step();
        dat[0] = 16'h1234; be[0] = 2'b01; step();
        we[0] = 1'b0; step();
        n_vec++;
        if (q_o[0][0] !== 16'hBE34 || qv_o[0][0] !== 1'b1) begin
            n_err++;
            $display("FAIL byte_write L1: q=%h qv=%b, required BE34 qv=1", q_o[0][0], qv_o[0][0]);
        end
        idle(); step();
        n_vec++;
        if (q_o[1][0] !== 16'hBE34 || qv_o[1][0] !== 1'b1 || q_o[0][0] !== 16'hBE34 || qv_o[0][0] !== 1'b0) begin
            n_err++;
            $display("FAIL byte_write L2/hold: q1=%h qv1=%b q0=%h qv0=%b, required BE34/1 BE34/0",
                     q_o[1][0], qv_o[1][0], q_o[0][0], qv_o[0][0]);
        end
    endtask

    task automatic test_rdw();
        idle();
        en[0] = 1'b1; we[0] = 1'b1; be[0] = 2'b11; addr[0] = 4'd5; dat[0] = 16'h5555; step();
        dat[0] = 16'hAAAA; step();
        n_vec++;
        if (q_o[0][0] !== 16'hAAAA || qv_o[0][0] !== 1'b1) begin
            n_err++;
            $display("FAIL rdw write_first: q=%h qv=%b, required AAAA qv=1", q_o[0][0], qv_o[0][0]);
        end
        idle(); step();
        n_vec++;
        if (q_o[1][0] !== 16'h5555 || qv_o[1][0] !== 1'b1) begin
            n_err++;
            $display("FAIL rdw read_first: q=%h qv=%b, required 5555 qv=1", q_o[1][0], qv_o[1][0]);
        end
    endtask

    task automatic test_cross_port();
        idle();
        en[0] = 1'b1; we[0] = 1'b1; be[0] = 2'b11; addr[0] = 4'd7; dat[0] = 16'h1111;
        en[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'd7;
        step();
        n_vec++;
        if (q_o[0][1] !== 16'h0000 || qv_o[0][1] !== 1'b1) begin
            n_err++;
            $display("FAIL cross_old L1: qb=%h qv=%b, required 0000 qv=1", q_o[0][1], qv_o[0][1]);
        end
        idle(); step();
        n_vec++;
        if (q_o[1][1] !== 16'h0000 || qv_o[1][1] !== 1'b1) begin
            n_err++;
            $display("FAIL cross_old L2: qb=%h qv=%b, required 0000 qv=1", q_o[1][1], qv_o[1][1]);
        end
        en[1] = 1'b1; addr[1] = 4'd7; step();
        n_vec++;
        if (q_o[0][1] !== 16'h1111) begin
            n_err++;
            $display("FAIL cross_new L1: qb=%h, required 1111", q_o[0][1]);
        end
        idle(); step();
        n_vec++;
        if (q_o[1][1] !== 16'h1111) begin
            n_err++;
            $display("FAIL cross_new L2: qb=%h, required 1111", q_o[1][1]);
        end
    endtask

    task automatic test_double_write();
        idle();
        en[0] = 1'b1; we[0] = 1'b1; be[0] = 2'b11; addr[0] = 4'd9; dat[0] = 16'hAAAA;
        en[1] = 1'b1; we[1] = 1'b1; be[1] = 2'b11; addr[1] = 4'd9; dat[1] = 16'hBBBB;
        step();
        n_vec++;
        if (col_o[0] !== 1'b1 || col_o[1] !== 1'b1 || q_o[0][0] !== 16'hAAAA || q_o[0][1] !== 16'hAAAA) begin
            n_err++;
            $display("FAIL dw_full: col0=%b col1=%b qa=%h qb=%h, required 1 1 AAAA AAAA",
                     col_o[0], col_o[1], q_o[0][0], q_o[0][1]);
        end
        idle(); en[0] = 1'b1; addr[0] = 4'd9; step();
        n_vec++;
        if (col_o[0] !== 1'b0 || col_o[1] !== 1'b0 || q_o[0][0] !== 16'hAAAA) begin
            n_err++;
            $display("FAIL dw_full_read: col0=%b col1=%b qa=%h, required 0 0 AAAA", col_o[0], col_o[1], q_o[0][0]);
        end
        idle(); step();
        n_vec++;
        if (q_o[1][0] !== 16'hBBBB) begin
            n_err++;
            $display("FAIL dw_pri_b: qa=%h, required BBBB", q_o[1][0]);
        end
        en[0] = 1'b1; we[0] = 1'b1; be[0] = 2'b10; addr[0] = 4'd9; dat[0] = 16'hAAAA;
        en[1] = 1'b1; we[1] = 1'b1; be[1] = 2'b01; addr[1] = 4'd9; dat[1] = 16'hBBBB;
        step();
        n_vec++;
        if (col_o[0] !== 1'b0 || col_o[1] !== 1'b0) begin
            n_err++;
            $display("FAIL dw_split_col: col0=%b col1=%b, required 0 0", col_o[0], col_o[1]);
        end
        idle(); en[0] = 1'b1; addr[0] = 4'd9; step();
        n_vec++;
        if (q_o[0][0] !== 16'hAABB) begin
            n_err++;
            $display("FAIL dw_split L1: qa=%h, required AABB", q_o[0][0]);
        end
        idle(); step();
        n_vec++;
        if (q_o[1][0] !== 16'hAABB) begin
            n_err++;
            $display("FAIL dw_split L2: qa=%h, required AABB", q_o[1][0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                en[p]   = ($urandom_range(0, 3) != 0);
                we[p]   = $urandom_range(0, 1);
                be[p]   = 2'($urandom_range(0, 3));
                addr[p] = 4'($urandom_range(0, 15));
                dat[p]  = 16'($urandom);
            end
            if ($urandom_range(0, 1) == 1) addr[1] = addr[0];
            step();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (init_o[d] !== mready || col_o[d] !== exp_col[d]) begin
                    n_err++;
                    $display("FAIL rand ctl dut%0d cyc %0d: init=%b col=%b, required %b %b",
                             d, c, init_o[d], col_o[d], mready, exp_col[d]);
                end
                for (int p = 0; p < 2; p++) begin
                    n_vec++;
                    if (q_o[d][p] !== exp_q[d][p] || qv_o[d][p] !== exp_qv[d][p]) begin
                        n_err++;
                        $display("FAIL rand q dut%0d port%0d cyc %0d: q=%h qv=%b, required %h %b",
                                 d, p, c, q_o[d][p], qv_o[d][p], exp_q[d][p], exp_qv[d][p]);
                    end
                end
            end
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid_fill();
        idle();
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        repeat (8) step();
        rst_n = 1'b0; step();
        n_vec++;
        if (init_o[0] !== 1'b0 || init_o[1] !== 1'b0 || qv_o[1][0] !== 1'b0 || q_o[1][0] !== 16'h0) begin
            n_err++;
            $display("FAIL mid_fill_reset: init0=%b init1=%b qv=%b q=%h, required 0 0 0 0000",
                     init_o[0], init_o[1], qv_o[1][0], q_o[1][0]);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            n_vec++;
            if (init_o[0] !== (i == 16) || init_o[1] !== (i == 16)) begin
                n_err++;
                $display("FAIL refill edge %0d: init0=%b init1=%b, required %b", i, init_o[0], init_o[1], i == 16);
            end
        end
    endtask

    initial begin
        mready = 1'b0;
        fcnt   = 0;
        for (int d = 0; d < 2; d++) begin
            exp_col[d] = 1'b0;
            for (int i = 0; i < 16; i++) mm[d][i] = '0;
            for (int p = 0; p < 2; p++) begin
                exp_q[d][p] = '0; exp_qv[d][p] = 1'b0; st_q[d][p] = '0; st_qv[d][p] = 1'b0;
            end
        end
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_fill();
        test_zero_reads();
        test_byte_write();
        test_rdw();
        test_cross_port();
        test_double_write();
        test_random();
        test_reset_mid_fill();
        test_zero_reads();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
